// File: rtl/spi_pkg.sv
// Shared types and constants for the Raspberry Pi SPI pixel link.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        IMG_CNT = 3'd2,
        PIX     = 3'd3,
        DROP    = 3'd4
    } stateT;

    localparam logic [7:0] CMD_IMG_TOT  = 8'h01;
    localparam logic [7:0] CMD_PIXELS   = 8'h02;
    localparam logic [7:0] IMG_MAX      = 8'd31;
    localparam logic       STATUS_READY = 1'b1;
    localparam int         PIX_W        = 24;

    // Status byte returned to the Pi: ready flag in the MSB, image count below it.
    function automatic logic [7:0] statusByte(input logic [7:0] imgTot);
        return {(imgTot != 8'd0) ? STATUS_READY : 1'b0, imgTot[6:0]};
    endfunction

endpackage

// File: rtl/spi_pixel_rx_if.sv
// Pin and pixel-write bundle between the SPI pins, the receiver and the memory unit.
interface spi_pixel_rx_if;
    import spi_pkg::*;

    logic             iSPI_SCLK;
    logic             iSPI_CS_N;
    logic             iSPI_MOSI;
    logic             oSPI_MISO;
    logic [PIX_W-1:0] oPix_Data;
    logic             oTrigger;
    logic [7:0]       oImg_Tot;
    logic [31:0]      oPix_Cnt;
    logic             oErr;
    stateT            oState;

    // oTrigger is a one-cycle valid with no ready: oPix_Data is stable while it is high
    // and held until the next trigger, so the consumer must take every pulse it sees.
    modport slave (
        input  iSPI_SCLK, iSPI_CS_N, iSPI_MOSI,
        output oSPI_MISO, oPix_Data, oTrigger, oImg_Tot, oPix_Cnt, oErr, oState
    );

    modport master (
        output iSPI_SCLK, iSPI_CS_N, iSPI_MOSI,
        input  oSPI_MISO, oPix_Data, oTrigger, oImg_Tot, oPix_Cnt, oErr, oState
    );

endinterface

// File: rtl/spi_slave_phy.sv
// Mode-0 SPI slave byte engine: synchronisers, edge detect, RX/TX shifters, byteValid.
module spi_slave_phy (
    input  logic       clk,
    input  logic       rstN,
    input  logic       sclk,
    input  logic       csN,
    input  logic       mosi,
    input  logic [7:0] txByte,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       csFall,
    output logic       csRise,
    output logic       midByte,
    output logic       miso
);

    logic [1:0] sclkSync;
    logic [1:0] csSync;
    logic [1:0] mosiSync;
    logic       sclkPrev;
    logic       csPrev;
    logic [2:0] bitCnt;
    logic [7:0] rxShift;
    logic [7:0] txShift;
    logic       sclkRise;
    logic       sclkFall;

    assign sclkRise = sclkSync[1] & ~sclkPrev;
    assign sclkFall = ~sclkSync[1] & sclkPrev;
    assign csFall   = ~csSync[1] & csPrev;
    assign csRise   = csSync[1] & ~csPrev;
    assign midByte  = (bitCnt != 3'd0);
    assign miso     = txShift[7];

    // CS_N synchronisers reset high so leaving reset never looks like a select edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sclkSync  <= 2'b00;
            csSync    <= 2'b11;
            mosiSync  <= 2'b00;
            sclkPrev  <= 1'b0;
            csPrev    <= 1'b1;
            bitCnt    <= 3'd0;
            rxShift   <= 8'd0;
            rxByte    <= 8'd0;
            byteValid <= 1'b0;
            txShift   <= 8'd0;
        end else begin
            sclkSync  <= {sclkSync[0], sclk};
            csSync    <= {csSync[0], csN};
            mosiSync  <= {mosiSync[0], mosi};
            sclkPrev  <= sclkSync[1];
            csPrev    <= csSync[1];
            byteValid <= 1'b0;

            if (csSync[1]) begin
                bitCnt  <= 3'd0;
                rxShift <= 8'd0;
            end else if (sclkRise) begin
                rxShift <= {rxShift[6:0], mosiSync[1]};
                bitCnt  <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    byteValid <= 1'b1;
                    rxByte    <= {rxShift[6:0], mosiSync[1]};
                end
            end

            if (csFall) begin
                txShift <= txByte;
            end else if (csSync[1]) begin
                txShift <= 8'd0;
            end else if (sclkFall) begin
                txShift <= {txShift[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_pixel_rx.sv
// Command decoder and RGB pixel assembler behind the SPI slave byte engine.
module spi_pixel_rx
    import spi_pkg::*;
(
    input  logic iCLK_50,
    input  logic iRST_N,
    spi_pixel_rx_if.slave spiBus
);

    logic             byteValid;
    logic [7:0]       rxByte;
    logic             csFall;
    logic             csRise;
    logic             midByte;
    logic             miso;

    stateT            state;
    stateT            stateNext;
    logic [1:0]       byteIdx;
    logic [1:0]       idxNext;
    logic [7:0]       rByte;
    logic [7:0]       gByte;
    logic [PIX_W-1:0] pixData;
    logic             trigger;
    logic [7:0]       imgTot;
    logic [31:0]      pixCnt;
    logic             err;

    logic             errNext;
    logic             pixDone;
    logic             imgLatch;
    logic             rLoad;
    logic             gLoad;

    spi_slave_phy uPhy (
        .clk       (iCLK_50),
        .rstN      (iRST_N),
        .sclk      (spiBus.iSPI_SCLK),
        .csN       (spiBus.iSPI_CS_N),
        .mosi      (spiBus.iSPI_MOSI),
        .txByte    (statusByte(imgTot)),
        .byteValid (byteValid),
        .rxByte    (rxByte),
        .csFall    (csFall),
        .csRise    (csRise),
        .midByte   (midByte),
        .miso      (miso)
    );

    always_comb begin
        stateNext = state;
        idxNext   = byteIdx;
        errNext   = 1'b0;
        pixDone   = 1'b0;
        imgLatch  = 1'b0;
        rLoad     = 1'b0;
        gLoad     = 1'b0;

        case (state)
            IDLE: if (csFall) stateNext = CMD;
            CMD: begin
                if (byteValid) begin
                    if (rxByte == CMD_IMG_TOT) begin
                        stateNext = IMG_CNT;
                    end else if (rxByte == CMD_PIXELS) begin
                        stateNext = PIX;
                        idxNext   = 2'd0;
                    end else begin
                        stateNext = DROP;
                        errNext   = 1'b1;
                    end
                end
            end
            IMG_CNT: begin
                if (byteValid) begin
                    stateNext = DROP;
                    if (rxByte != 8'd0 && rxByte <= IMG_MAX) imgLatch = 1'b1;
                    else                                     errNext  = 1'b1;
                end
            end
            PIX: begin
                if (byteValid) begin
                    case (byteIdx)
                        2'd0:    begin rLoad = 1'b1; idxNext = 2'd1; end
                        2'd1:    begin gLoad = 1'b1; idxNext = 2'd2; end
                        default: begin pixDone = 1'b1; idxNext = 2'd0; end
                    endcase
                end
            end
            DROP:    stateNext = DROP;
            default: stateNext = IDLE;
        endcase

        // A byte landing in the same cycle as deselect is consumed above before this
        // check, so only a genuinely truncated byte or pixel raises the error.
        if (csRise) begin
            stateNext = IDLE;
            if (midByte || (state == PIX && idxNext != 2'd0)) errNext = 1'b1;
            idxNext = 2'd0;
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            byteIdx <= 2'd0;
            rByte   <= 8'd0;
            gByte   <= 8'd0;
            pixData <= '0;
            trigger <= 1'b0;
            imgTot  <= 8'd0;
            pixCnt  <= 32'd0;
            err     <= 1'b0;
        end else begin
            state   <= stateNext;
            byteIdx <= idxNext;
            err     <= errNext;
            trigger <= pixDone;
            if (rLoad)    rByte  <= rxByte;
            if (gLoad)    gByte  <= rxByte;
            if (imgLatch) imgTot <= rxByte;
            if (pixDone) begin
                pixData <= {rByte, gByte, rxByte};
                pixCnt  <= pixCnt + 32'd1;
            end
        end
    end

    assign spiBus.oSPI_MISO = miso;
    assign spiBus.oPix_Data = pixData;
    assign spiBus.oTrigger  = trigger;
    assign spiBus.oImg_Tot  = imgTot;
    assign spiBus.oPix_Cnt  = pixCnt;
    assign spiBus.oErr      = err;
    assign spiBus.oState    = state;

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Bench for spi_pixel_rx: directed protocol steps plus random pixel/count transfers.
module tb_spi_pixel_rx;
    import spi_pkg::*;

    localparam int HP = 8;

    logic iCLK_50 = 1'b0;
    logic iRST_N  = 1'b0;

    spi_pixel_rx_if bus ();

    spi_pixel_rx dut (
        .iCLK_50 (iCLK_50),
        .iRST_N  (iRST_N),
        .spiBus  (bus)
    );

    always #10 iCLK_50 = ~iCLK_50;

    int          checks = 0;
    int          errors = 0;
    int          errSeen = 0;
    int          errExp = 0;
    int          popCnt = 0;
    int          pixExp = 0;
    logic [7:0]  imgTotModel = 8'd0;
    logic [23:0] lastPix = 24'd0;
    logic [23:0] expPixQ[$];
    logic [7:0]  txQ[$];
    logic        prevTrig = 1'b0;
    logic        prevBv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every trigger must match the next expected pixel.
    always @(negedge iCLK_50) begin
        if (!iRST_N) begin
            popCnt   = 0;
            prevTrig = 1'b0;
            prevBv   = 1'b0;
        end else begin
            if (bus.oErr) errSeen++;
            if (bus.oTrigger) begin
                check("trigger_spacing", 32'(prevTrig), 32'd0);
                check("trigger_latency", 32'(prevBv), 32'd1);
                check("trigger_expected", 32'(expPixQ.size() > 0), 32'd1);
                if (expPixQ.size() > 0) begin
                    logic [23:0] e;
                    e = expPixQ.pop_front();
                    popCnt++;
                    check("pix_data", 32'(bus.oPix_Data), 32'(e));
                    check("pix_cnt_at_trigger", bus.oPix_Cnt, 32'(popCnt));
                end
            end
            prevTrig = bus.oTrigger;
            prevBv   = dut.byteValid;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge iCLK_50);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int nBits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nBits; i--) begin
            bus.iSPI_MOSI = b[i];
            waitClk(HP);
            rx[i] = bus.oSPI_MISO;
            bus.iSPI_SCLK = 1'b1;
            waitClk(HP);
            bus.iSPI_SCLK = 1'b0;
        end
    endtask

    // Predicts a whole transfer from the protocol rules, then drives it and checks.
    task automatic runTransfer(input int extraBits, input string tag);
        logic [7:0] rx;
        logic [7:0] status;
        int         n;
        status = {(imgTotModel != 8'd0), imgTotModel[6:0]};
        n = txQ.size();
        if (n == 0) begin
            if (extraBits > 0) errExp++;
        end else if (txQ[0] == 8'h01) begin
            if (n >= 2) begin
                if (txQ[1] >= 8'd1 && txQ[1] <= 8'd31) imgTotModel = txQ[1];
                else                                   errExp++;
            end
            if (extraBits > 0) errExp++;
        end else if (txQ[0] == 8'h02) begin
            for (int p = 1; p + 2 < n; p += 3) begin
                lastPix = {txQ[p], txQ[p+1], txQ[p+2]};
                expPixQ.push_back(lastPix);
                pixExp++;
            end
            if (((n - 1) % 3) != 0 || extraBits > 0) errExp++;
        end else begin
            errExp++;
            if (extraBits > 0) errExp++;
        end

        bus.iSPI_CS_N = 1'b0;
        waitClk(HP);
        for (int k = 0; k < n; k++) begin
            sendByte(txQ[k], 8, rx);
            check({tag, "_miso"}, 32'(rx), (k == 0) ? 32'(status) : 32'd0);
        end
        if (extraBits > 0) sendByte(8'hA5, extraBits, rx);
        waitClk(HP);
        bus.iSPI_CS_N = 1'b1;
        waitClk(4 * HP);

        check({tag, "_img_tot"}, 32'(bus.oImg_Tot), 32'(imgTotModel));
        check({tag, "_err_cnt"}, 32'(errSeen), 32'(errExp));
        check({tag, "_pix_cnt"}, bus.oPix_Cnt, 32'(pixExp));
        check({tag, "_pending"}, 32'(expPixQ.size()), 32'd0);
        check({tag, "_pix_hold"}, 32'(bus.oPix_Data), 32'(lastPix));
        check({tag, "_state"}, 32'(bus.oState), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] rx;
        int         np;
        bus.iSPI_SCLK = 1'b0;
        bus.iSPI_CS_N = 1'b1;
        bus.iSPI_MOSI = 1'b0;
        iRST_N = 1'b0;
        waitClk(3);
        check("rst_pix_data", 32'(bus.oPix_Data), 32'd0);
        check("rst_trigger", 32'(bus.oTrigger), 32'd0);
        check("rst_img_tot", 32'(bus.oImg_Tot), 32'd0);
        check("rst_pix_cnt", bus.oPix_Cnt, 32'd0);
        check("rst_err", 32'(bus.oErr), 32'd0);
        check("rst_miso", 32'(bus.oSPI_MISO), 32'd0);
        check("rst_state", 32'(bus.oState), 32'(IDLE));
        iRST_N = 1'b1;
        waitClk(4);

        txQ = '{8'h01, 8'h05};                               runTransfer(0, "img_tot5");
        txQ = '{8'h02};                                      runTransfer(0, "status85");
        txQ = '{8'h02, 8'hFF, 8'h80, 8'h01, 8'h12, 8'h34, 8'h56}; runTransfer(0, "two_pix");
        txQ = '{8'h02, 8'hAA, 8'hBB};                        runTransfer(0, "part_pix");
        txQ.delete();                                        runTransfer(5, "part_byte");
        txQ = '{8'h02, 8'h01, 8'h02, 8'h03};                 runTransfer(0, "after_part");
        txQ = '{8'h01, 8'h00};                               runTransfer(0, "img_zero");
        txQ = '{8'h01, 8'h40};                               runTransfer(0, "img_big");
        txQ = '{8'h07};                                      runTransfer(0, "bad_cmd");

        for (int t = 0; t < 4; t++) begin
            txQ = '{8'h02};
            np = $urandom_range(1, 4);
            for (int j = 0; j < np * 3 + $urandom_range(0, 2); j++)
                txQ.push_back(8'($urandom_range(0, 255)));
            runTransfer(($urandom_range(0, 1) == 1) ? 3 : 0, "rnd_pix");
            txQ = '{8'h01, 8'($urandom_range(0, 40))};
            runTransfer(0, "rnd_img");
        end

        // Reset in the middle of the G byte.
        bus.iSPI_CS_N = 1'b0;
        waitClk(HP);
        sendByte(8'h02, 8, rx);
        sendByte(8'h0A, 8, rx);
        sendByte(8'h0B, 4, rx);
        iRST_N = 1'b0;
        #1;
        check("mid_rst_pix_data", 32'(bus.oPix_Data), 32'd0);
        check("mid_rst_trigger", 32'(bus.oTrigger), 32'd0);
        check("mid_rst_img_tot", 32'(bus.oImg_Tot), 32'd0);
        check("mid_rst_pix_cnt", bus.oPix_Cnt, 32'd0);
        check("mid_rst_err", 32'(bus.oErr), 32'd0);
        check("mid_rst_miso", 32'(bus.oSPI_MISO), 32'd0);
        check("mid_rst_state", 32'(bus.oState), 32'(IDLE));
        bus.iSPI_CS_N = 1'b1;
        bus.iSPI_SCLK = 1'b0;
        imgTotModel = 8'd0;
        pixExp = 0;
        lastPix = 24'd0;
        expPixQ.delete();
        waitClk(3);
        iRST_N = 1'b1;
        waitClk(4);
        txQ = '{8'h02, 8'h0A, 8'h0B, 8'h0C};                 runTransfer(0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_pixel_rx.md
Name: spi_pixel_rx

Overview:
SPI slave front end that turns the Raspberry Pi byte stream into the pixel-write interface of the memory management unit. It decodes a simple command protocol and assembles R,G,B bytes into 24-bit pixels, each announced by a one-cycle trigger. It also latches the total image count for the slideshow. Sits between the DE0-Nano GPIO SPI pins and the SDRAM write path, in the 50 MHz system domain.

Parameters:
CMD_IMG_TOT, 8'h01, command byte: the next byte is the total image count
CMD_PIXELS, 8'h02, command byte: pixel bytes follow, R then G then B, until CS_N rises
IMG_MAX, 8'd31, largest accepted image count (the downstream image index is 5 bits)
STATUS_READY, 1'b1, value of the MSB of the status byte when at least one image count has been latched

Ports:
iCLK_50  in  1  system clock, 50 MHz
iRST_N  in  1  asynchronous active-low reset
iSPI_SCLK  in  1  SPI clock from the Pi, asynchronous, mode 0, at most 6.25 MHz (fCLK/8)
iSPI_CS_N  in  1  SPI chip select, active low, asynchronous
iSPI_MOSI  in  1  SPI data in, MSB first
oSPI_MISO  out  1  SPI data out, MSB first
oPix_Data  out  24  last assembled pixel {R,G,B}
oTrigger  out  1  one-cycle pulse per complete pixel
oImg_Tot  out  8  latched total image count
oPix_Cnt  out  32  pixels received since reset
oErr  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values: oPix_Data=0, oTrigger=0, oImg_Tot=0, oPix_Cnt=0, oErr=0, oSPI_MISO=0, FSM=IDLE.
- Synchronisers:
  - SCLK, CS_N and MOSI each pass through 2 flip-flops.
  - SCLK rising and falling edges are detected on the synchronised copy.
  - MOSI is sampled on the detected rising edge.
- Bit counter (3 bits) and shift register (8 bits):
  - Both are cleared while CS_N is high.
  - A byte is complete on the 8th rising edge, which produces an internal byte_valid pulse for one cycle.
- MISO:
  - On the CS_N falling edge the status byte {STATUS_READY if oImg_Tot!=0 else 0, oImg_Tot[6:0]} loads into the TX shift register.
  - The TX register shifts on each SCLK falling edge and shifts in 0 after the status byte.
  - oSPI_MISO is driven from the TX MSB.
- FSM states IDLE, CMD, IMG_CNT, PIX, DROP:
  - IDLE: CS_N falling -> CMD.
  - CMD, byte_valid: CMD_IMG_TOT -> IMG_CNT; CMD_PIXELS -> PIX with byte index 0; any other value -> DROP with an oErr pulse.
  - IMG_CNT, byte_valid:
    - A value in 1..IMG_MAX latches into oImg_Tot.
    - 0 or a value > IMG_MAX leaves oImg_Tot unchanged and pulses oErr.
    - Either way -> DROP; extra bytes are ignored.
  - PIX, byte_valid: store the byte in the R/G/B slot given by the byte index (0,1,2).
    - At index 2: oPix_Data <= {R,G,B} and oTrigger=1 in the next cycle; oPix_Cnt increments in that same cycle; index wraps to 0.
    - Latency: oTrigger and the new oPix_Data appear 1 clk after the internal byte_valid of the B byte.
  - DROP: ignore bytes until CS_N rises.
  - Any state, synchronised CS_N rising -> IDLE.
- Boundary conditions:
  - CS_N rising mid-byte (bit counter != 0) or mid-pixel (index != 0) pulses oErr once. The partial byte or pixel is discarded and no trigger is issued.
  - If CS_N rises in the same cycle as byte_valid, the byte is processed first, then the FSM returns to IDLE.
  - oPix_Cnt wraps modulo 2^32.
  - The next pixel stream continues the count; the FSM does not clear it.
- oPix_Data holds its value between triggers.
- oTrigger never asserts in two consecutive cycles.
- Asynchronous reset mid-transfer returns every register to its reset value immediately.

Decomposition:
- Shared package spi_pkg:
  - state enum typedef (IDLE, CMD, IMG_CNT, PIX, DROP)
  - CMD_IMG_TOT and CMD_PIXELS constants
  - IMG_MAX constant
  - PIX_W=24 constant
- Sub-module spi_slave_phy: synchronisers, edge detect, RX/TX shift registers, byte_valid. It is reusable for the other SPI links.
- spi_pixel_rx contains the command FSM and the pixel assembler.

Test Plan:
- Reset, then CS_N low and send 01 05, CS_N high -> oImg_Tot=5; MISO returns 00 then 00.
- Next transfer, send 02 -> MISO first byte = 0x85.
- Send 02 FF 80 01 12 34 56 -> two oTrigger pulses with oPix_Data=FF8001 then 123456; oPix_Cnt=2; each trigger 1 clk after the B byte's byte_valid.
- Send 02 AA BB, CS_N high -> no trigger; one oErr; oPix_Data unchanged.
- CS_N high after 5 bits, then send 02 01 02 03 -> one oErr; trigger with 010203.
- Send 01 00, then 01 40, then 07 -> three oErr pulses; oImg_Tot keeps its prior value.
- Assert iRST_N low during the G byte -> all outputs 0; after release, 02 0A 0B 0C -> trigger 0A0B0C with oPix_Cnt=1.
